rtr_opc_credit_tracker: RTL and testbench
=========================================

// Module: rtr_opc_credit_tracker
//
// PURPOSE
//  Tracks downstream buffer credits for each (output port, packet class) pair.
//  It produces the flat per-port/per-class flag vectors that the router's flags
//  mux reduces to a single port/class selection. The block sits between the
//  switch-allocation grant path (credit consumption) and the incoming credit
//  channels (credit return).
//
// PARAMETERS
//  num_message_classes   2  message classes (e.g. request, reply)
//  num_resource_classes  2  resource classes (e.g. minimal, adaptive)
//  num_ports             5  router output ports
//  buffer_size           8  downstream buffer depth per packet class (>=1)
//  derived: num_packet_classes = num_message_classes*num_resource_classes;
//           cnt_width = clogb(buffer_size+1)
//
// PORTS
//  clk               input   1                                clock
//  reset             input   1                                async, active-high
//  send_valid        input   1                                flit leaves this cycle
//  send_op           input   [0:num_ports-1]                  one-hot output port of flit
//  send_opc          input   [0:num_packet_classes-1]         one-hot packet class of flit
//  cred_op_opc       input   [0:num_ports*num_packet_classes-1]  credit return pulses
//  cred_avail_op_opc output  [0:num_ports*num_packet_classes-1]  count > 0
//  empty_op_opc      output  [0:num_ports*num_packet_classes-1]  count == buffer_size
//  error_op_opc      output  [0:num_ports*num_packet_classes-1]  sticky under/overflow
//
// BEHAVIOUR
//  - Interface is fixed: one clock, clk. reset is asynchronous and active-high.
//  - Flat index of (op, opc) = op*num_packet_classes + opc; bit 0 is port 0, class 0.
//  - One counter per (op, opc), cnt_width bits. Counters reset to buffer_size.
//  - Reset values of every output:
//    - cred_avail_op_opc = all 1s
//    - empty_op_opc      = all 1s
//    - error_op_opc      = all 0s
//  - dec(op,opc) = send_valid & send_op[op] & send_opc[opc].
//  - inc(op,opc) = cred_op_opc[idx].
//  - Counter update rules per clk edge:
//    - dec & ~inc: count - 1.
//    - inc & ~dec: count + 1.
//    - both or neither: count unchanged. A same-cycle send and return net to zero.
//  - Underflow: dec & ~inc with count==0.
//    - Counter holds at 0.
//    - error bit for that (op, opc) sets.
//  - Overflow: inc & ~dec with count==buffer_size.
//    - Counter holds at buffer_size.
//    - error bit for that (op, opc) sets.
//  - error bits are sticky; only reset clears them.
//  - Flags are combinational decodes of the registered counts. The flags for an
//    event at edge N are visible in the cycle after edge N (1-cycle latency). No
//    bypass of same-cycle inputs to the flags.
//  - Selects must be one-hot when send_valid=1.
//    - All-zero send_op or send_opc: no counter changes.
//    - Multi-hot selects: every selected (op, opc) pair decrements. This is not
//      flagged; the bench treats it as illegal stimulus.
//  - Assertion of reset mid-operation: all counters immediately return to
//    buffer_size and all error bits clear, regardless of in-flight pulses.
//  - No handshake back-pressure. The block always accepts inputs; consumers use
//    cred_avail to gate allocation.
//
// TESTING (num_ports=5, 2x2 classes, buffer_size=8)
//  1. Reset release, no traffic
//     -> avail=all 1s, empty=all 1s, error=0 for all 20 bits.
//  2. 8 sends to op=2, opc=1 (idx 9) on consecutive cycles
//     -> empty[9]=0 after 1st send; avail[9]=0 after 8th send; all other bits
//        unchanged; error[9]=0.
//  3. From count 0 on idx 9, a 9th send
//     -> count stays 0, error[9]=1 and stays 1. Then 8 returns
//     -> empty[9]=1, error[9] still 1.
//  4. idx 9 at count 3: send and cred_op_opc[9] in the same cycle for 4 cycles
//     -> count stays 3, avail=1, empty=0 throughout.
//  5. idx 0 at buffer_size, extra return pulse
//     -> count holds 8, error[0]=1. Send to idx 4 and return to idx 7 in the
//        same cycle -> each moves independently.
//  6. Drain idx 5 to count 2, assert reset asynchronously between edges
//     -> outputs reach reset values before the next clk edge; traffic after
//        deassertion starts from 8.

Source files
------------

// File: rtl/rtr_opc_credit_tracker.sv
// Credit counters per (output port, packet class) pair, producing flat
// credit-available / buffer-empty / sticky-error flag vectors for the flags mux.
module rtr_opc_credit_cell #(
  parameter int buffer_size = 8,
  localparam int cnt_width = $clog2(buffer_size + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic dec,
  input  logic inc,
  output logic avail,
  output logic empty,
  output logic error
);
  localparam logic [cnt_width-1:0] full_cnt = cnt_width'(buffer_size);
  localparam logic [cnt_width-1:0] one_cnt  = cnt_width'(1);

  logic [cnt_width-1:0] cnt;

  // Simultaneous send and return cancel; out-of-range moves saturate and latch error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= full_cnt;
      error <= 1'b0;
    end else if (dec && !inc) begin
      if (cnt == '0) error <= 1'b1;
      else           cnt   <= cnt - one_cnt;
    end else if (inc && !dec) begin
      if (cnt == full_cnt) error <= 1'b1;
      else                 cnt   <= cnt + one_cnt;
    end
  end

  assign avail = (cnt != '0);
  assign empty = (cnt == full_cnt);
endmodule

module rtr_opc_credit_tracker #(
  parameter int num_message_classes  = 2,
  parameter int num_resource_classes = 2,
  parameter int num_ports            = 5,
  parameter int buffer_size          = 8,
  localparam int num_packet_classes  = num_message_classes * num_resource_classes,
  localparam int num_pairs           = num_ports * num_packet_classes
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          send_valid,
  input  logic [0:num_ports-1]          send_op,
  input  logic [0:num_packet_classes-1] send_opc,
  input  logic [0:num_pairs-1]          cred_op_opc,
  output logic [0:num_pairs-1]          cred_avail_op_opc,
  output logic [0:num_pairs-1]          empty_op_opc,
  output logic [0:num_pairs-1]          error_op_opc
);
  // Flat index = op*num_packet_classes + opc; bit 0 is port 0, class 0.
  for (genvar op = 0; op < num_ports; op++) begin : g_op
    for (genvar opc = 0; opc < num_packet_classes; opc++) begin : g_opc
      localparam int idx = op * num_packet_classes + opc;
      logic dec;
      assign dec = send_valid & send_op[op] & send_opc[opc];

      rtr_opc_credit_cell #(.buffer_size(buffer_size)) u_cell (
        .clk   (clk),
        .reset (reset),
        .dec   (dec),
        .inc   (cred_op_opc[idx]),
        .avail (cred_avail_op_opc[idx]),
        .empty (empty_op_opc[idx]),
        .error (error_op_opc[idx])
      );
    end
  end
endmodule

// File: tb/tb_rtr_opc_credit_tracker.sv
// Directed-vector bench: stimulus pushes expected flag vectors into a queue,
// a negedge monitor pops and compares against the DUT.
module tb_rtr_opc_credit_tracker;
  localparam int NP  = 5;
  localparam int NC  = 4;
  localparam int NB  = NP * NC;
  localparam int BUF = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic send_valid = 1'b0;
  logic [0:NP-1] send_op = '0;
  logic [0:NC-1] send_opc = '0;
  logic [0:NB-1] cred_op_opc = '0;
  logic [0:NB-1] avail, empty, error;

  always #5 clk = ~clk;

  rtr_opc_credit_tracker #(
    .num_message_classes(2), .num_resource_classes(2),
    .num_ports(NP), .buffer_size(BUF)
  ) dut (
    .clk(clk), .reset(reset), .send_valid(send_valid), .send_op(send_op),
    .send_opc(send_opc), .cred_op_opc(cred_op_opc),
    .cred_avail_op_opc(avail), .empty_op_opc(empty), .error_op_opc(error)
  );

  typedef struct {
    string         name;
    logic [0:NB-1] av;
    logic [0:NB-1] em;
    logic [0:NB-1] er;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   mcnt[NB];
  logic merr[NB];

  task automatic cmp(input string name, input logic [0:NB-1] act, input logic [0:NB-1] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp({e.name, ".avail"}, avail, e.av);
      cmp({e.name, ".empty"}, empty, e.em);
      cmp({e.name, ".error"}, error, e.er);
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      mcnt[i] = BUF;
      merr[i] = 1'b0;
    end
  endfunction

  task automatic push_exp(input string name);
    exp_t e;
    e.name = name;
    for (int i = 0; i < NB; i++) begin
      e.av[i] = (mcnt[i] != 0);
      e.em[i] = (mcnt[i] == BUF);
      e.er[i] = merr[i];
    end
    q.push_back(e);
  endtask

  // Apply one cycle of inputs; after the edge, advance the model and queue the expectation.
  task automatic step(input string name, input logic v, input logic [0:NP-1] op,
                      input logic [0:NC-1] opc, input logic [0:NB-1] cr);
    @(negedge clk);
    send_valid = v; send_op = op; send_opc = opc; cred_op_opc = cr;
    @(posedge clk);
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < NC; c++) begin
        int  i;
        logic d, n;
        i = p * NC + c;
        d = v & op[p] & opc[c];
        n = cr[i];
        if (d && !n) begin
          if (mcnt[i] == 0) merr[i] = 1'b1; else mcnt[i]--;
        end else if (n && !d) begin
          if (mcnt[i] == BUF) merr[i] = 1'b1; else mcnt[i]++;
        end
      end
    push_exp(name);
  endtask

  function automatic logic [0:NP-1] oh_op(input int p);
    logic [0:NP-1] r;
    r = '0; r[p] = 1'b1;
    return r;
  endfunction

  function automatic logic [0:NC-1] oh_c(input int c);
    logic [0:NC-1] r;
    r = '0; r[c] = 1'b1;
    return r;
  endfunction

  function automatic logic [0:NB-1] oh_cr(input int i);
    logic [0:NB-1] r;
    r = '0; r[i] = 1'b1;
    return r;
  endfunction

  localparam logic [0:NB-1] NOCR = '0;

  initial begin
    model_reset();
    #1 push_exp("in_reset");
    @(negedge clk); #2 reset = 1'b0;

    step("idle", 1'b0, '0, '0, NOCR);

    // idx 9 = op 2, class 1: drain fully, then underflow
    for (int k = 0; k < 8; k++) step("drain9", 1'b1, oh_op(2), oh_c(1), NOCR);
    step("under9", 1'b1, oh_op(2), oh_c(1), NOCR);
    step("under9_hold", 1'b0, '0, '0, NOCR);
    for (int k = 0; k < 8; k++) step("refill9", 1'b0, '0, '0, oh_cr(9));

    // Bring idx 9 to 3, then net-zero send+return
    for (int k = 0; k < 5; k++) step("to3_9", 1'b1, oh_op(2), oh_c(1), NOCR);
    for (int k = 0; k < 4; k++) step("net0_9", 1'b1, oh_op(2), oh_c(1), oh_cr(9));

    // Overflow idx 0; then independent moves on idx 4 and idx 7
    step("over0", 1'b0, '0, '0, oh_cr(0));
    step("pre7", 1'b1, oh_op(1), oh_c(3), NOCR);
    step("ind4_7", 1'b1, oh_op(1), oh_c(0), oh_cr(7));

    // Valid with all-zero class select moves nothing
    step("zero_opc", 1'b1, oh_op(3), '0, NOCR);
    step("zero_op", 1'b1, '0, oh_c(2), NOCR);

    // Drain idx 5 to 2, then async reset between edges
    for (int k = 0; k < 6; k++) step("drain5", 1'b1, oh_op(1), oh_c(1), NOCR);
    step("idle5", 1'b0, '0, '0, NOCR);
    @(negedge clk);
    send_valid = 1'b1; send_op = oh_op(1); send_opc = oh_c(1); cred_op_opc = oh_cr(0);
    @(posedge clk);
    for (int p = 0; p < NP; p++)
      for (int c = 0; c < NC; c++)
        if (p == 1 && c == 1) begin
          if (mcnt[5] > 0) mcnt[5]--;
        end
    push_exp("pre_rst");
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    push_exp("async_rst");
    @(negedge clk);
    send_valid = 1'b0; send_op = '0; send_opc = '0; cred_op_opc = '0;
    #2 reset = 1'b0;
    step("post_rst5", 1'b1, oh_op(1), oh_c(1), NOCR);
    step("post_rst_idle", 1'b0, '0, '0, NOCR);

    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_queue: %0d pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
